// File: rtl/dp_grant_sched.sv
// Two-channel grant scheduler: each cycle the two highest eligible requesters are
// granted onto idle channels, with a served mask that grants each requester once per round.
module dp_grant_sched #(
    parameter int N        = 12,
    parameter int IW       = 4,
    parameter int HOLD_MAX = 16,
    parameter int CW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] ch0_id,
    output logic [IW-1:0] ch1_id,
    output logic [1:0]    ch_busy,
    output logic [1:0]    timeout
);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    ch_state_e         ch_state_q [2];
    ch_state_e         ch_state_d [2];
    logic [IW-1:0]     ch_id_q    [2];
    logic [IW-1:0]     ch_id_d    [2];
    logic [CW-1:0]     ch_cnt_q   [2];
    logic [CW-1:0]     ch_cnt_d   [2];
    logic [1:0]        timeout_q;
    logic [1:0]        timeout_d;
    logic [N-1:0]      mask_q;
    logic [N-1:0]      mask_d;
    logic [N-1:0]      gnt_q;
    logic [N-1:0]      gnt_d;

    logic [N-1:0]      elig;
    logic [IW-1:0]     first_id;
    logic [IW-1:0]     second_id;
    logic [IW-1:0]     grant_id   [2];
    logic              hold_done  [2];
    logic              hold_req   [2];
    logic              hold_last  [2];

    // Id of the highest set bit (bit i maps to id i+1); 0 when the vector is empty.
    function automatic logic [IW-1:0] top_id(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = IW'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] id_onehot(input logic [IW-1:0] id);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (id == IW'(i + 1)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Bit of a per-requester vector belonging to id; id 0 (no holder) reads as 0.
    function automatic logic bit_of(input logic [N-1:0] v, input logic [IW-1:0] id);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (id == IW'(i + 1)) begin
                r = v[i];
            end
        end
        return r;
    endfunction

    // Arbitration only looks at channels that are idle now; a channel releasing
    // at this edge is still busy, so it always spends one cycle idle.
    always_comb begin
        elig        = req & ~mask_q & ~gnt_q;
        first_id    = top_id(elig);
        second_id   = top_id(elig & ~id_onehot(first_id));
        grant_id[0] = '0;
        grant_id[1] = '0;
        if (ch_state_q[0] == CH_IDLE && ch_state_q[1] == CH_IDLE) begin
            grant_id[0] = first_id;
            grant_id[1] = second_id;
        end else if (ch_state_q[0] == CH_IDLE) begin
            grant_id[0] = first_id;
        end else if (ch_state_q[1] == CH_IDLE) begin
            grant_id[1] = first_id;
        end
    end

    always_comb begin
        timeout_d = '0;
        for (int c = 0; c < 2; c++) begin
            ch_state_d[c] = ch_state_q[c];
            ch_id_d[c]    = ch_id_q[c];
            ch_cnt_d[c]   = ch_cnt_q[c];
            hold_done[c]  = bit_of(done, ch_id_q[c]);
            hold_req[c]   = bit_of(req, ch_id_q[c]);
            hold_last[c]  = (ch_cnt_q[c] == CW'(HOLD_MAX - 1));
            case (ch_state_q[c])
                CH_IDLE: begin
                    if (grant_id[c] != '0) begin
                        ch_state_d[c] = CH_BUSY;
                        ch_id_d[c]    = grant_id[c];
                        ch_cnt_d[c]   = '0;
                    end
                end
                CH_BUSY: begin
                    if (hold_done[c] || !hold_req[c] || hold_last[c]) begin
                        ch_state_d[c] = CH_IDLE;
                        ch_id_d[c]    = '0;
                        ch_cnt_d[c]   = '0;
                        // Timeout is reported only when the counter alone forced the release.
                        timeout_d[c]  = hold_last[c] && !hold_done[c] && hold_req[c];
                    end else begin
                        ch_cnt_d[c] = ch_cnt_q[c] + CW'(1);
                    end
                end
                default: begin
                    ch_state_d[c] = CH_IDLE;
                    ch_id_d[c]    = '0;
                    ch_cnt_d[c]   = '0;
                end
            endcase
        end
    end

    // An empty eligible set ends the round; no grant can happen on that edge.
    always_comb begin
        if (elig == '0) begin
            mask_d = '0;
        end else begin
            mask_d = mask_q | id_onehot(grant_id[0]) | id_onehot(grant_id[1]);
        end
        gnt_d = id_onehot(ch_id_d[0]) | id_onehot(ch_id_d[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                ch_state_q[c] <= CH_IDLE;
                ch_id_q[c]    <= '0;
                ch_cnt_q[c]   <= '0;
            end
            timeout_q <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                ch_state_q[c] <= ch_state_d[c];
                ch_id_q[c]    <= ch_id_d[c];
                ch_cnt_q[c]   <= ch_cnt_d[c];
            end
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign ch0_id  = ch_id_q[0];
    assign ch1_id  = ch_id_q[1];
    assign ch_busy = {ch_state_q[1] == CH_BUSY, ch_state_q[0] == CH_BUSY};
    assign timeout = timeout_q;

endmodule

// File: tb/tb_dp_grant_sched.sv
// Bench for dp_grant_sched: directed scenarios with literal expectations plus random
// traffic, all outputs compared every cycle against a holder/age/served-set model.
module tb_dp_grant_sched;

    localparam int N        = 12;
    localparam int IW       = 4;
    localparam int HOLD_MAX = 16;
    localparam int CW       = 5;
    localparam int W        = N + 2 * IW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] ch0_id;
    logic [IW-1:0] ch1_id;
    logic [1:0]    ch_busy;
    logic [1:0]    timeout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dp_grant_sched #(.N(N), .IW(IW), .HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .ch0_id  (ch0_id),
        .ch1_id  (ch1_id),
        .ch_busy (ch_busy),
        .timeout (timeout)
    );

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel holds an id and the number of cycles it has been visible.
    int           m_id  [2];
    int           m_age [2];
    bit           m_served [N+1];
    logic [1:0]   m_to;
    int           picks[$];
    int           idle_ch[$];
    logic [N-1:0] m_held;
    logic [N-1:0] m_gnt;

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_id[c]  = 0;
            m_age[c] = 0;
        end
        for (int i = 0; i <= N; i++) m_served[i] = 1'b0;
        m_to = '0;
    end

    always @(posedge clk) begin
        m_to = '0;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_id[c]  = 0;
                m_age[c] = 0;
            end
            for (int i = 0; i <= N; i++) m_served[i] = 1'b0;
        end else begin
            m_held = '0;
            for (int c = 0; c < 2; c++) if (m_id[c] != 0) m_held[m_id[c]-1] = 1'b1;
            picks.delete();
            for (int id = N; id >= 1; id--)
                if (req[id-1] && !m_served[id] && !m_held[id-1]) picks.push_back(id);
            idle_ch.delete();
            for (int c = 0; c < 2; c++) if (m_id[c] == 0) idle_ch.push_back(c);
            for (int c = 0; c < 2; c++) begin
                if (m_id[c] != 0) begin
                    if (done[m_id[c]-1] || !req[m_id[c]-1] || m_age[c] >= HOLD_MAX) begin
                        m_to[c]  = !done[m_id[c]-1] && req[m_id[c]-1];
                        m_id[c]  = 0;
                        m_age[c] = 0;
                    end else begin
                        m_age[c]++;
                    end
                end
            end
            for (int k = 0; k < idle_ch.size() && k < picks.size(); k++) begin
                m_id[idle_ch[k]]   = picks[k];
                m_age[idle_ch[k]]  = 1;
                m_served[picks[k]] = 1'b1;
            end
            if (picks.size() == 0)
                for (int i = 0; i <= N; i++) m_served[i] = 1'b0;
        end
        m_gnt = '0;
        for (int c = 0; c < 2; c++) if (m_id[c] != 0) m_gnt[m_id[c]-1] = 1'b1;
        exp_q.push_back({m_gnt, IW'(m_id[0]), IW'(m_id[1]),
                         (m_id[1] != 0), (m_id[0] != 0), m_to});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_gnt",     32'(gnt),     32'(e[W-1 -: N]));
            check_val("sb_ch0_id",  32'(ch0_id),  32'(e[2*IW+3 -: IW]));
            check_val("sb_ch1_id",  32'(ch1_id),  32'(e[IW+3 -: IW]));
            check_val("sb_ch_busy", 32'(ch_busy), 32'(e[3:2]));
            check_val("sb_timeout", 32'(timeout), 32'(e[1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_after_reset(input logic [N-1:0] r);
        reset = 1'b1;
        req   = r;
        done  = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] dv;
        reset = 1'b1;
        req   = 12'hFFF;
        done  = '0;

        // Reset holds everything at zero even with all requests up.
        repeat (2) tick();
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_ch0", 32'(ch0_id), 32'h0);
        check_val("rst_ch1", 32'(ch1_id), 32'h0);
        check_val("rst_busy", 32'(ch_busy), 32'h0);
        check_val("rst_timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        tick();
        check_val("first_ch0", 32'(ch0_id), 32'd12);
        check_val("first_ch1", 32'(ch1_id), 32'd11);
        check_val("first_gnt", 32'(gnt), 32'hC00);
        check_val("first_busy", 32'(ch_busy), 32'h3);

        // Done release followed by round clear and regrant.
        start_after_reset(12'h0A0);
        tick();
        check_val("done_ch0_pre", 32'(ch0_id), 32'd8);
        check_val("done_ch1_pre", 32'(ch1_id), 32'd6);
        done = 12'h080;
        tick();
        done = '0;
        check_val("done_ch0_rel", 32'(ch0_id), 32'd0);
        check_val("done_gnt_rel", 32'(gnt), 32'h020);
        tick();
        check_val("done_ch0_regrant", 32'(ch0_id), 32'd8);

        // Fairness: every id once per round in descending pairs.
        start_after_reset(12'hFFF);
        for (int r = 0; r < 6; r++) begin
            tick();
            check_val("fair_ch0", 32'(ch0_id), 32'(12 - 2 * r));
            check_val("fair_ch1", 32'(ch1_id), 32'(11 - 2 * r));
            dv = '0;
            dv[11 - 2 * r] = 1'b1;
            dv[10 - 2 * r] = 1'b1;
            done = dv;
            tick();
            done = '0;
            check_val("fair_idle", 32'(ch_busy), 32'h0);
        end
        tick();
        check_val("fair_wrap_ch0", 32'(ch0_id), 32'd12);
        check_val("fair_wrap_ch1", 32'(ch1_id), 32'd11);

        // Timeout after HOLD_MAX visible cycles.
        start_after_reset(12'h001);
        for (int i = 0; i < HOLD_MAX; i++) begin
            tick();
            check_val("to_hold_ch0", 32'(ch0_id), 32'd1);
            check_val("to_hold_pulse", 32'(timeout), 32'h0);
        end
        tick();
        check_val("to_rel_ch0", 32'(ch0_id), 32'd0);
        check_val("to_pulse", 32'(timeout), 32'h1);
        tick();
        check_val("to_regrant_ch0", 32'(ch0_id), 32'd1);
        check_val("to_pulse_end", 32'(timeout), 32'h0);

        // Request drop releases without timeout.
        start_after_reset(12'h00C);
        tick();
        check_val("drop_ch0_pre", 32'(ch0_id), 32'd4);
        check_val("drop_ch1_pre", 32'(ch1_id), 32'd3);
        req = 12'h008;
        tick();
        check_val("drop_ch1", 32'(ch1_id), 32'd0);
        check_val("drop_timeout", 32'(timeout), 32'h0);
        check_val("drop_gnt", 32'(gnt), 32'h008);

        // Reset while both channels are mid-grant.
        start_after_reset(12'hFFF);
        repeat (8) tick();
        check_val("mid_busy", 32'(ch_busy), 32'h3);
        reset = 1'b1;
        tick();
        check_val("mid_rst_gnt", 32'(gnt), 32'h0);
        check_val("mid_rst_busy", 32'(ch_busy), 32'h0);
        check_val("mid_rst_ch0", 32'(ch0_id), 32'h0);
        reset = 1'b0;
        tick();
        check_val("mid_restart_ch0", 32'(ch0_id), 32'd12);
        check_val("mid_restart_ch1", 32'(ch1_id), 32'd11);

        // Random traffic against the model.
        req = 12'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) == 0) req = 12'($urandom);
            else if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N-1)] ^= 1'b1;
            done  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : '0;
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        done  = '0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
